// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit RISC CPU sequencer: opcodes, FSM states,
// the control-strobe bundle and its per-state decode.
package cpu_pkg;

   localparam int CTL_OPC_W  = 3;
   localparam int CTL_STEP_W = 3;

   localparam logic [CTL_OPC_W-1:0] HLT  = 3'b000;
   localparam logic [CTL_OPC_W-1:0] SKZ  = 3'b001;
   localparam logic [CTL_OPC_W-1:0] ADD  = 3'b010;
   localparam logic [CTL_OPC_W-1:0] ANDD = 3'b011;
   localparam logic [CTL_OPC_W-1:0] XORR = 3'b100;
   localparam logic [CTL_OPC_W-1:0] LDA  = 3'b101;
   localparam logic [CTL_OPC_W-1:0] STO  = 3'b110;
   localparam logic [CTL_OPC_W-1:0] JMP  = 3'b111;

   typedef enum logic [CTL_STEP_W:0] {
      S0     = 4'd0,
      S1     = 4'd1,
      S2     = 4'd2,
      S3     = 4'd3,
      S4     = 4'd4,
      S5     = 4'd5,
      S6     = 4'd6,
      S7     = 4'd7,
      HALTED = 4'd8
   } state_t;

   typedef struct packed {
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic load_ir;
      logic rd;
      logic wr;
      logic datactl_ena;
      logic halt;
   } ctl_t;

   // Strobes to be driven while the FSM sits in state s.
   function automatic ctl_t decode(
      input state_t               s,
      input logic [CTL_OPC_W-1:0] op,
      input logic                 z
   );
      ctl_t c;
      logic alu;
      c   = '0;
      alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
      case (s)
         S0: begin
            c.rd      = 1'b1;
            c.load_ir = 1'b1;
         end
         S1: begin
            c.rd      = 1'b1;
            c.load_ir = 1'b1;
            c.inc_pc  = 1'b1;
         end
         S3: begin
            c.inc_pc = 1'b1;
            c.halt   = (op == HLT);
         end
         S4: begin
            unique case (1'b1)
               op == JMP: c.load_pc     = 1'b1;
               alu:       c.rd          = 1'b1;
               op == STO: c.datactl_ena = 1'b1;
               default: ;
            endcase
         end
         S5: begin
            unique case (1'b1)
               alu: begin
                  c.rd       = 1'b1;
                  c.load_acc = 1'b1;
               end
               op == SKZ: c.inc_pc = z;
               op == JMP: begin
                  c.load_pc = 1'b1;
                  c.inc_pc  = 1'b1;
               end
               op == STO: begin
                  c.wr          = 1'b1;
                  c.datactl_ena = 1'b1;
               end
               default: ;
            endcase
         end
         S6: begin
            unique case (1'b1)
               op == STO: c.datactl_ena = 1'b1;
               alu:       c.rd          = 1'b1;
               default: ;
            endcase
         end
         S7:      c.inc_pc = (op == SKZ) && z;
         HALTED:  c.halt   = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/machine_ena.sv
// Sticky arming latch: set by the first fetch strobe after reset,
// cleared only by the synchronous active-low reset.
module machine_ena (
   input  logic clk,
   input  logic reset,
   input  logic fetch,
   output logic ena
);

   always_ff @(posedge clk) begin
      if (!reset)
         ena <= 1'b0;
      else if (fetch)
         ena <= 1'b1;
   end

endmodule

// File: rtl/machine_ctl.sv
// Instruction-sequencing controller: 8-step FSM with registered strobes.
// Define MACHINE_CTL_HALT_STICKY_EN to make HLT park the FSM in HALTED.
import cpu_pkg::*;

module machine_ctl #(
   parameter int OPC_W  = CTL_OPC_W,
   parameter int STEP_W = CTL_STEP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   output logic             inc_pc,
   output logic             load_pc,
   output logic             load_acc,
   output logic             load_ir,
   output logic             rd,
   output logic             wr,
   output logic             datactl_ena,
   output logic             halt
);

   state_t state, state_nxt;
   ctl_t   ctl, ctl_nxt;
   logic   ena;
   logic   [STEP_W-1:0] step_inc;

   machine_ena u_ena (
      .clk   (clk),
      .reset (reset),
      .fetch (fetch),
      .ena   (ena)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S0;
         ctl   <= '0;
      end else begin
         state <= state_nxt;
         ctl   <= ctl_nxt;
      end
   end

   // Step counter wraps S7 -> S0 through the natural 3-bit overflow.
   assign step_inc = state[STEP_W-1:0] + STEP_W'(1);

   always_comb begin
      state_nxt = S0;
      ctl_nxt   = '0;
      if (!ena) begin
         // The arming edge itself enters S0 with its fetch strobes.
         if (fetch)
            ctl_nxt = decode(S0, opcode, zero);
      end else begin
`ifdef MACHINE_CTL_HALT_STICKY_EN
         if (state == HALTED || (state == S3 && ctl.halt))
            state_nxt = HALTED;
         else
            state_nxt = state_t'({1'b0, step_inc});
`else
         state_nxt = state_t'({1'b0, step_inc});
`endif
         ctl_nxt = decode(state_nxt, opcode, zero);
      end
   end

   assign inc_pc      = ctl.inc_pc;
   assign load_pc     = ctl.load_pc;
   assign load_acc    = ctl.load_acc;
   assign load_ir     = ctl.load_ir;
   assign rd          = ctl.rd;
   assign wr          = ctl.wr;
   assign datactl_ena = ctl.datactl_ena;
   assign halt        = ctl.halt;

endmodule

// File: tb/tb_machine_ctl.sv
// Self-checking bench for machine_ctl against an instruction-level
// reference model; honours MACHINE_CTL_HALT_STICKY_EN.
module tb_machine_ctl;

   localparam logic [2:0] O_HLT  = 3'b000;
   localparam logic [2:0] O_SKZ  = 3'b001;
   localparam logic [2:0] O_ADD  = 3'b010;
   localparam logic [2:0] O_ANDD = 3'b011;
   localparam logic [2:0] O_XORR = 3'b100;
   localparam logic [2:0] O_LDA  = 3'b101;
   localparam logic [2:0] O_STO  = 3'b110;
   localparam logic [2:0] O_JMP  = 3'b111;

`ifdef MACHINE_CTL_HALT_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       fetch  = 1'b0;
   logic       zero   = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;

   int vectors = 0;
   int errors  = 0;

   bit         m_ena    = 1'b0;
   bit         m_halted = 1'b0;
   int         m_step   = 0;
   logic [7:0] m_exp    = 8'h00;

   wire [7:0] obs = {inc_pc, load_pc, load_acc, load_ir,
                     rd, wr, datactl_ena, halt};

   machine_ctl dut (
      .clk         (clk),
      .reset       (reset),
      .fetch       (fetch),
      .opcode      (opcode),
      .zero        (zero),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_acc    (load_acc),
      .load_ir     (load_ir),
      .rd          (rd),
      .wr          (wr),
      .datactl_ena (datactl_ena),
      .halt        (halt)
   );

   always #5 clk = ~clk;

   // Strobes per step, one boolean rule per strobe.
   function automatic logic [7:0] model_ctl(int s, logic [2:0] op, logic z);
      bit alu, f_inc, f_lpc, f_lacc, f_lir, f_rd, f_wr, f_den, f_hlt;
      alu    = op inside {O_ADD, O_ANDD, O_XORR, O_LDA};
      f_lir  = s <= 1;
      f_rd   = s <= 1 || (alu && s inside {4, 5, 6});
      f_inc  = s == 1 || s == 3 || (op == O_SKZ && z && s inside {5, 7})
               || (op == O_JMP && s == 5);
      f_lpc  = op == O_JMP && s inside {4, 5};
      f_lacc = alu && s == 5;
      f_wr   = op == O_STO && s == 5;
      f_den  = op == O_STO && s inside {4, 5, 6};
      f_hlt  = op == O_HLT && s == 3;
      return {f_inc, f_lpc, f_lacc, f_lir, f_rd, f_wr, f_den, f_hlt};
   endfunction

   task automatic tick(input string tag);
      @(posedge clk);
      if (!reset) begin
         m_ena = 0; m_halted = 0; m_step = 0; m_exp = 8'h00;
      end else if (m_halted) begin
         m_exp = 8'h01;
      end else if (!m_ena) begin
         m_step = 0;
         m_exp  = 8'h00;
         if (fetch) begin
            m_ena = 1;
            m_exp = model_ctl(0, opcode, zero);
         end
      end else if (STICKY && m_step == 3 && m_exp[0]) begin
         m_halted = 1;
         m_exp    = 8'h01;
      end else begin
         m_step = (m_step + 1) % 8;
         m_exp  = model_ctl(m_step, opcode, zero);
      end
      @(negedge clk);
      vectors++;
      if (obs !== m_exp) begin
         errors++;
         $display("FAIL %s step=%0d got=%b want=%b", tag, m_step, obs, m_exp);
      end
      vectors++;
      if ((rd && wr) || (wr && !datactl_ena)) begin
         errors++;
         $display("FAIL invariant_%s got rd=%b wr=%b den=%b want rd&wr=0, wr->den",
                  tag, rd, wr, datactl_ena);
      end
   endtask

   task automatic align_s7();
      int n = 0;
      while (m_step != 7 && n < 16) begin
         tick("align");
         n++;
      end
      vectors++;
      if (m_step != 7) begin
         errors++;
         $display("FAIL align got step=%0d want 7", m_step);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fetch  = 1'($urandom);
         opcode = 3'($urandom);
         tick("reset");
      end
      fetch = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) tick("idle");
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL idle got=%b want=00000000", obs);
      end
   endtask

   task automatic test_arm();
      fetch = 1'b1;
      tick("arm_s0");
      fetch = 1'b0;
      vectors++;
      if (obs !== 8'b0001_1000) begin
         errors++;
         $display("FAIL arm_s0 got=%b want=00011000", obs);
      end
      tick("arm_s1");
      vectors++;
      if (obs !== 8'b1001_1000) begin
         errors++;
         $display("FAIL arm_s1 got=%b want=10011000", obs);
      end
   endtask

   task automatic test_opcode(input logic [2:0] op, input logic z,
                              input int want_inc);
      int cnt = 0;
      opcode = op;
      zero   = z;
      align_s7();
      for (int s = 0; s < 8; s++) begin
         if (op != O_SKZ) zero = 1'($urandom);
         tick("opcode");
         cnt += int'(inc_pc);
      end
      vectors++;
      if (cnt != want_inc) begin
         errors++;
         $display("FAIL inc_count op=%b z=%b got=%0d want=%0d", op, z, cnt, want_inc);
      end
   endtask

   task automatic test_mid_reset();
      opcode = O_ADD;
      align_s7();
      for (int s = 0; s < 6; s++) tick("pre_rst");
      reset = 1'b0;
      tick("mid_rst");
      reset = 1'b1;
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst got=%b want=00000000", obs);
      end
      for (int i = 0; i < 12; i++) tick("post_rst");
   endtask

   task automatic test_fetch_in_reset();
      reset = 1'b0;
      fetch = 1'b1;
      tick("fetch_rst");
      reset = 1'b1;
      fetch = 1'b0;
      for (int i = 0; i < 6; i++) tick("fetch_rst_idle");
      vectors++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL fetch_rst got=%b want=00000000", obs);
      end
   endtask

   task automatic test_hlt();
      int hcnt = 0;
      fetch = 1'b1;
      tick("hlt_arm");
      fetch  = 1'b0;
      opcode = O_HLT;
      for (int s = 0; s < 3; s++) tick("hlt_s");
      vectors++;
      if (halt !== 1'b1) begin
         errors++;
         $display("FAIL hlt_s3 got halt=%b want 1", halt);
      end
      for (int i = 0; i < 50; i++) begin
         opcode = 3'($urandom);
         tick("hlt_after");
         hcnt += int'(halt);
      end
      vectors++;
      if (hcnt != (STICKY ? 50 : 0) + (STICKY ? 0 : hcnt)) begin
         errors++;
         $display("FAIL hlt_count got=%0d", hcnt);
      end
      reset = 1'b0;
      tick("hlt_rst");
      reset = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 99) != 0);
         fetch  = ($urandom_range(0, 15) == 0);
         opcode = 3'($urandom);
         zero   = 1'($urandom);
         tick("random");
      end
      reset = 1'b1;
      fetch = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_arm();
      test_opcode(O_ADD, 1'b0, 2);
      test_opcode(O_STO, 1'b0, 2);
      test_opcode(O_SKZ, 1'b1, 4);
      test_opcode(O_SKZ, 1'b0, 2);
      test_opcode(O_JMP, 1'b0, 3);
      test_opcode(O_ANDD, 1'b1, 2);
      test_opcode(O_XORR, 1'b0, 2);
      test_opcode(O_LDA, 1'b1, 2);
      test_mid_reset();
      test_fetch_in_reset();
      test_hlt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
